ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 121 ++++++++++++
 tb/tb_ifetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Latency: the instruction word at PC appears on IF_ID_Instruction one rising edge after PC is presented.
// Backpressure: Stall holds PC and IF/ID; a redirect overrides Stall for the PC; Flush or a redirect bubbles IF/ID.
//
// Ports:
//   Clk, Reset            clock and asynchronous active-low reset
//   Stall, Flush          hold / bubble controls from the hazard unit
//   Branch, BranchTaken,
//   BranchTarget          resolved conditional branch
//   Jump, JumpTarget      resolved unconditional jump (wins over a taken branch)
//   IMemData / IMemAddr   combinational instruction memory read port
//   PC                    current program counter
//   IF_ID_*               registered instruction, PC+4, valid bit, and opcode/funct slices
//   InstrCount            saturating count of valid IF/ID loads
//   AlignErr              sticky: some redirect target had nonzero bits [1:0]
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Branch,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] IMemData,
    output logic [31:0] IMemAddr,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [5:0]  IF_ID_Opcode,
    output logic [5:0]  IF_ID_Funct,
    output logic [31:0] InstrCount,
    output logic        AlignErr
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q,  pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic        align_q, align_d;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] pc_plus4;
    logic        load_valid;

    assign redirect   = Jump | (Branch & BranchTaken);
    // Jump takes precedence when both redirect sources fire together.
    assign target_raw = Jump ? JumpTarget : BranchTarget;
    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 32'h0.
    assign pc_plus4   = pc_q + 32'd4;
    assign load_valid = !(Flush | redirect) && !Stall;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        count_d = count_q;
        align_d = align_q;

        // Redirect beats Stall for the PC; the low two bits are forced to word alignment.
        if (redirect) begin
            pc_d = {target_raw[31:2], 2'b00};
        end else if (!Stall) begin
            pc_d = pc_plus4;
        end

        if (Flush | redirect) begin
            instr_d = 32'h0;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
        end else if (!Stall) begin
            instr_d = IMemData;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end

        if (load_valid && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end

        if (redirect && (target_raw[1:0] != 2'b00)) begin
            align_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
            count_q <= 32'h0;
            align_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            count_q <= count_d;
            align_q <= align_d;
        end
    end

    assign IMemAddr          = pc_q;
    assign PC                = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pcp4_q;
    assign IF_ID_Valid       = valid_q;
    assign IF_ID_Opcode      = instr_q[31:26];
    assign IF_ID_Funct       = instr_q[5:0];
    assign InstrCount        = count_q;
    assign AlignErr          = align_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall, Flush, Branch, BranchTaken, Jump;
    logic [31:0] BranchTarget, JumpTarget, IMemData;
    logic [31:0] IMemAddr, PC, IF_ID_Instruction, IF_ID_PCPlus4, InstrCount;
    logic        IF_ID_Valid, AlignErr;
    logic [5:0]  IF_ID_Opcode, IF_ID_Funct;

    int total = 0;
    int bad   = 0;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .Branch(Branch), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .IMemData(IMemData),
        .IMemAddr(IMemAddr), .PC(PC), .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid),
        .IF_ID_Opcode(IF_ID_Opcode), .IF_ID_Funct(IF_ID_Funct),
        .InstrCount(InstrCount), .AlignErr(AlignErr)
    );

    always #5 Clk = ~Clk;

    // Address-indexed instruction memory: every word is nonzero and unique per address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[7:0] ^ 8'h5A, 8'hC3, a[15:0]};
    endfunction

    assign IMemData = imem(IMemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling and driving.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle();
        Stall = 0; Flush = 0; Branch = 0; BranchTaken = 0; Jump = 0;
        BranchTarget = 32'h0; JumpTarget = 32'h0;
    endtask

    logic [31:0] w;

    initial begin
        idle();
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #1;
        check("rst_pc",    PC, 32'h0);
        check("rst_instr", IF_ID_Instruction, 32'h0);
        check("rst_pcp4",  IF_ID_PCPlus4, 32'h0);
        check("rst_valid", {31'b0, IF_ID_Valid}, 32'h0);
        check("rst_cnt",   InstrCount, 32'h0);
        check("rst_align", {31'b0, AlignErr}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;

        // Sequential fetch from reset.
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_pc",    PC, 32'(4 * (i + 1)));
            check("seq_instr", IF_ID_Instruction, imem(32'(4 * i)));
            check("seq_pcp4",  IF_ID_PCPlus4, 32'(4 * (i + 1)));
            check("seq_valid", {31'b0, IF_ID_Valid}, 32'h1);
        end
        check("seq_cnt",  InstrCount, 32'd3);
        check("imemaddr", IMemAddr, 32'hC);
        w = imem(32'h8);
        check("opcode", {26'b0, IF_ID_Opcode}, {26'b0, w[31:26]});
        check("funct",  {26'b0, IF_ID_Funct},  {26'b0, w[5:0]});

        step();
        check("pc_10", PC, 32'h10);

        // Stall for two edges.
        Stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_pc",    PC, 32'h10);
            check("stall_instr", IF_ID_Instruction, imem(32'hC));
            check("stall_cnt",   InstrCount, 32'd4);
        end
        Stall = 0;

        for (int i = 0; i < 4; i++) step();
        check("pc_20",  PC, 32'h20);
        check("cnt_8",  InstrCount, 32'd8);

        // Taken branch overrides Stall and bubbles IF/ID.
        Branch = 1; BranchTaken = 1; BranchTarget = 32'h100; Stall = 1;
        step();
        idle();
        check("br_pc",    PC, 32'h100);
        check("br_valid", {31'b0, IF_ID_Valid}, 32'h0);
        check("br_instr", IF_ID_Instruction, 32'h0);
        check("br_pcp4",  IF_ID_PCPlus4, 32'h0);
        check("br_cnt",   InstrCount, 32'd8);

        // Not-taken branch is plain sequential fetch.
        Branch = 1; BranchTaken = 0; BranchTarget = 32'h300;
        step();
        idle();
        check("nt_pc",    PC, 32'h104);
        check("nt_instr", IF_ID_Instruction, imem(32'h100));
        check("nt_valid", {31'b0, IF_ID_Valid}, 32'h1);
        check("nt_cnt",   InstrCount, 32'd9);

        // Flush with Stall: bubble, PC held.
        Flush = 1; Stall = 1;
        step();
        idle();
        check("fs_pc",    PC, 32'h104);
        check("fs_valid", {31'b0, IF_ID_Valid}, 32'h0);
        check("fs_cnt",   InstrCount, 32'd9);

        // Flush alone: bubble, PC advances.
        Flush = 1;
        step();
        idle();
        check("fl_pc",    PC, 32'h108);
        check("fl_valid", {31'b0, IF_ID_Valid}, 32'h0);
        check("align_0",  {31'b0, AlignErr}, 32'h0);

        // Jump beats taken branch; misaligned target is aligned and flagged.
        Jump = 1; JumpTarget = 32'h202; Branch = 1; BranchTaken = 1; BranchTarget = 32'h300;
        step();
        idle();
        check("jmp_pc",    PC, 32'h200);
        check("jmp_align", {31'b0, AlignErr}, 32'h1);
        check("jmp_valid", {31'b0, IF_ID_Valid}, 32'h0);
        step();
        step();
        check("sticky_pc",    PC, 32'h208);
        check("sticky_align", {31'b0, AlignErr}, 32'h1);
        check("sticky_instr", IF_ID_Instruction, imem(32'h204));
        check("sticky_cnt",   InstrCount, 32'd11);

        // PC wraparound.
        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        step();
        idle();
        check("wrap_pre", PC, 32'hFFFF_FFFC);
        step();
        check("wrap_pc",    PC, 32'h0);
        check("wrap_pcp4",  IF_ID_PCPlus4, 32'h0);
        check("wrap_instr", IF_ID_Instruction, imem(32'hFFFF_FFFC));
        check("wrap_valid", {31'b0, IF_ID_Valid}, 32'h1);
        step();
        check("post_wrap_pc", PC, 32'h4);
        check("cnt_13",       InstrCount, 32'd13);

        // Reset pulse between edges while a redirect is being presented.
        Jump = 1; JumpTarget = 32'h400;
        #2 Reset = 1'b0;
        #1;
        check("mr_pc",    PC, 32'h0);
        check("mr_instr", IF_ID_Instruction, 32'h0);
        check("mr_valid", {31'b0, IF_ID_Valid}, 32'h0);
        check("mr_cnt",   InstrCount, 32'h0);
        check("mr_align", {31'b0, AlignErr}, 32'h0);
        idle();
        #1 Reset = 1'b1;
        step();
        check("rel_pc",    PC, 32'h4);
        check("rel_instr", IF_ID_Instruction, imem(32'h0));
        check("rel_cnt",   InstrCount, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
